// File: rtl/audio_dsm_out.sv
// Audio output stage: fixed-rate sample capture, soft-mute gain ramp, 2nd-order CIFB delta-sigma.
// Define AUDIO_DSM_DITHER_EN to add a 1-LSB LFSR dither ahead of the modulator.
module audio_dsm_out #(
   parameter int SAMPLE_DIV = 255,
   parameter int INT_W      = 12
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] sample,
   input  logic       enable,
   input  logic       mute,
   output logic       dsm_out,
   output logic       sample_tick,
   output logic       muted
);
   localparam int DIV_W = $clog2(SAMPLE_DIV);
   localparam int SUM_W = INT_W + 2;
   localparam logic [DIV_W-1:0]        DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
   localparam logic [4:0]              GAIN_MAX = 5'd16;
   localparam logic signed [SUM_W-1:0] SAT_HI   = SUM_W'((2 ** (INT_W - 1)) - 1);
   localparam logic signed [SUM_W-1:0] SAT_LO   = -SAT_HI;
   localparam logic signed [SUM_W-1:0] FB_MAG   = SUM_W'(128);

   typedef enum logic [1:0] {
      ST_MUTED     = 2'd0,
      ST_RAMP_UP   = 2'd1,
      ST_RUN       = 2'd2,
      ST_RAMP_DOWN = 2'd3
   } state_t;

   function automatic logic signed [INT_W-1:0] sat(input logic signed [SUM_W-1:0] v);
      logic signed [SUM_W-1:0] c;
      if (v > SAT_HI) c = SAT_HI;
      else if (v < SAT_LO) c = SAT_LO;
      else c = v;
      return c[INT_W-1:0];
   endfunction

   logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
   logic                    tick_s, tick_q;
   logic [7:0]              hold_q, hold_d;
   logic [4:0]              gain_q, gain_d;
   state_t                  state_q, state_d;
   logic                    muted_q, muted_d;
   logic signed [7:0]       x_q, x_d, xm_s;
   logic signed [8:0]       c_s;
   logic signed [14:0]      prod_s;
   logic signed [SUM_W-1:0] fb_s;
   logic signed [INT_W-1:0] i1_q, i1_d, i2_q, i2_d;
   logic                    dsm_q, dsm_d;

   // Sample-rate divider, capture register and gain scaling
   always_comb begin
      tick_s = (div_cnt_q == DIV_LAST);
      if (tick_s) begin
         div_cnt_d = '0;
         hold_d    = sample;
      end else begin
         div_cnt_d = div_cnt_q + DIV_W'(1);
         hold_d    = hold_q;
      end
      c_s    = $signed({1'b0, hold_q}) - 9'sd128;
      prod_s = 15'(c_s) * 15'($signed({1'b0, gain_q}));
      x_d    = prod_s[11:4];
   end

   // Gain FSM next state; only tick edges move it, so mute glitches between ticks are ignored
   always_comb begin
      state_d = state_q;
      gain_d  = gain_q;
      if (tick_s) begin
         case (state_q)
            ST_MUTED: begin
               if (!mute) state_d = ST_RAMP_UP;
               else       state_d = ST_MUTED;
            end
            ST_RAMP_UP: begin
               if (mute) begin
                  state_d = ST_RAMP_DOWN;
               end else if (gain_q >= GAIN_MAX - 5'd1) begin
                  gain_d  = GAIN_MAX;
                  state_d = ST_RUN;
               end else begin
                  gain_d  = gain_q + 5'd1;
               end
            end
            ST_RUN: begin
               if (mute) state_d = ST_RAMP_DOWN;
               else      state_d = ST_RUN;
            end
            ST_RAMP_DOWN: begin
               if (!mute) begin
                  state_d = ST_RAMP_UP;
               end else if (gain_q <= 5'd1) begin
                  gain_d  = 5'd0;
                  state_d = ST_MUTED;
               end else begin
                  gain_d  = gain_q - 5'd1;
               end
            end
            default: begin
               state_d = ST_MUTED;
               gain_d  = 5'd0;
            end
         endcase
      end else begin
         state_d = state_q;
         gain_d  = gain_q;
      end
   end

   // FSM output, registered alongside the state
   always_comb begin
      muted_d = (state_d == ST_MUTED);
   end

`ifdef AUDIO_DSM_DITHER_EN
   logic [15:0]       lfsr_q, lfsr_d;
   logic signed [8:0] xd_s;

   // Galois LFSR dither source; LSB added to x with clamp at +127
   always_comb begin
      if (lfsr_q[0]) lfsr_d = (lfsr_q >> 1) ^ 16'hB400;
      else           lfsr_d = lfsr_q >> 1;
      xd_s = $signed({x_q[7], x_q}) + $signed({8'd0, lfsr_q[0]});
      if (xd_s > 9'sd127) xm_s = 8'sd127;
      else                xm_s = xd_s[7:0];
   end

   // LFSR register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       lfsr_q <= 16'hACE1;
      else if (!enable) lfsr_q <= 16'hACE1;
      else              lfsr_q <= lfsr_d;
   end
`else
   // Undithered path
   always_comb begin
      xm_s = x_q;
   end
`endif

   // CIFB modulator; i2 integrates the old i1
   always_comb begin
      if (dsm_q) fb_s = FB_MAG;
      else       fb_s = -FB_MAG;
      i1_d  = sat(SUM_W'(i1_q) + SUM_W'(xm_s) - fb_s);
      i2_d  = sat(SUM_W'(i2_q) + SUM_W'(i1_q) - fb_s);
      dsm_d = ~i2_d[INT_W-1];
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_MUTED;
         gain_q  <= 5'd0;
         muted_q <= 1'b1;
      end else if (!enable) begin
         state_q <= ST_MUTED;
         gain_q  <= 5'd0;
         muted_q <= 1'b1;
      end else begin
         state_q <= state_d;
         gain_q  <= gain_d;
         muted_q <= muted_d;
      end
   end

   // Datapath registers; enable=0 clears synchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_q <= '0;
         tick_q    <= 1'b0;
         hold_q    <= 8'h80;
         x_q       <= 8'sd0;
         i1_q      <= '0;
         i2_q      <= '0;
         dsm_q     <= 1'b0;
      end else if (!enable) begin
         div_cnt_q <= '0;
         tick_q    <= 1'b0;
         hold_q    <= 8'h80;
         x_q       <= 8'sd0;
         i1_q      <= '0;
         i2_q      <= '0;
         dsm_q     <= 1'b0;
      end else begin
         div_cnt_q <= div_cnt_d;
         tick_q    <= tick_s;
         hold_q    <= hold_d;
         x_q       <= x_d;
         i1_q      <= i1_d;
         i2_q      <= i2_d;
         dsm_q     <= dsm_d;
      end
   end

   assign dsm_out     = dsm_q;
   assign sample_tick = tick_q;
   assign muted       = muted_q;
endmodule

// File: tb/tb_audio_dsm_out.sv
// Scoreboard bench for audio_dsm_out: per-tick gain/muted/x expectations plus ones-density windows.
`timescale 1ns/1ps
module tb_audio_dsm_out;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enable = 1'b1;
   logic       mute = 1'b0;
   logic [7:0] sample = 8'h80;
   logic       dsm_out, sample_tick, muted;

   always #5 clk = ~clk;

   audio_dsm_out dut (
      .clk(clk), .rst_n(rst_n), .sample(sample), .enable(enable), .mute(mute),
      .dsm_out(dsm_out), .sample_tick(sample_tick), .muted(muted)
   );

   typedef struct {
      logic [4:0]        gain;
      logic              muted;
      logic signed [7:0] x;
   } exp_t;

   exp_t sb_q[$];
   int   total = 0;
   int   bad = 0;

   function automatic exp_t mk(input int g, input int m, input int x);
      exp_t e;
      e.gain  = 5'(g);
      e.muted = 1'(m);
      e.x     = 8'(x);
      return e;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      total++;
      if (act < lo || act > hi) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic wait_tick(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!sample_tick && n < 400);
      if (!sample_tick) begin
         total++;
         bad++;
         $display("FAIL tick_timeout: no sample_tick in %0d clocks, expected one within 255", n);
      end
   endtask

   task automatic count_ones(input int clocks, output int ones);
      ones = 0;
      repeat (clocks) begin
         @(negedge clk);
         ones += int'(dsm_out);
      end
   endtask

   // Monitor: on every sample_tick pop one expectation; x is checked a clock later
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (sample_tick && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("tick_gain", int'(dut.gain_q), int'(e.gain));
            check("tick_muted", int'(muted), int'(e.muted));
            @(negedge clk);
            check("tick_x", int'(dut.x_q), int'(e.x));
         end
      end
   end

   initial begin : stim
      int n;
      int ones;
      repeat (3) @(negedge clk);
      check("rst_dsm_out", int'(dsm_out), 0);
      check("rst_sample_tick", int'(sample_tick), 0);
      check("rst_muted", int'(muted), 1);
      check("rst_gain", int'(dut.gain_q), 0);

      // Power-up ramp at midscale: MUTED -> RAMP_UP (gain 0) -> 1..16 -> RUN
      sb_q.push_back(mk(0, 0, 0));
      for (int k = 1; k <= 17; k++) sb_q.push_back(mk((k > 16) ? 16 : k, 0, 0));
      rst_n = 1'b1;
      wait_tick(n);
      check("first_tick_latency", n, 255);
      wait_tick(n);
      check("tick_period", n, 255);
      repeat (16) wait_tick(n);

      // Full-scale positive
      sample = 8'hFF;
      sb_q.push_back(mk(16, 0, 127));
      wait_tick(n);
      repeat (64) @(negedge clk);
      count_ones(4096, ones);
      check_range("ones_x127", ones, 4078, 4082);

      // Full-scale negative, then back to midscale
      sample = 8'h00;
      sb_q.push_back(mk(16, 0, -128));
      wait_tick(n);
      repeat (64) @(negedge clk);
      count_ones(1024, ones);
      check("ones_xm128", ones, 0);
      sample = 8'h80;
      sb_q.push_back(mk(16, 0, 0));
      wait_tick(n);
      repeat (2000) @(negedge clk);
      count_ones(4096, ones);
      check_range("ones_x0", ones, 2046, 2050);

      // Mute glitch between ticks is ignored
      sample = 8'hC0;
      sb_q.push_back(mk(16, 0, 64));
      wait_tick(n);
      repeat (100) @(negedge clk);
      mute = 1'b1;
      repeat (10) @(negedge clk);
      mute = 1'b0;
      sb_q.push_back(mk(16, 0, 64));
      wait_tick(n);

      // Ramp down to 8, reverse, ramp back up to 16
      mute = 1'b1;
      sb_q.push_back(mk(16, 0, 64));
      for (int g = 15; g >= 8; g--) sb_q.push_back(mk(g, 0, 4 * g));
      repeat (9) wait_tick(n);
      mute = 1'b0;
      sb_q.push_back(mk(8, 0, 32));
      for (int g = 9; g <= 16; g++) sb_q.push_back(mk(g, 0, 4 * g));
      sb_q.push_back(mk(16, 0, 64));
      repeat (10) wait_tick(n);

      // Async reset mid-RAMP_DOWN, between clock edges
      mute = 1'b1;
      sb_q.push_back(mk(16, 0, 64));
      sb_q.push_back(mk(15, 0, 60));
      sb_q.push_back(mk(14, 0, 56));
      repeat (3) wait_tick(n);
      repeat (100) @(negedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_dsm_out", int'(dsm_out), 0);
      check("async_muted", int'(muted), 1);
      check("async_sample_tick", int'(sample_tick), 0);
      check("async_gain", int'(dut.gain_q), 0);
      @(negedge clk);
      mute = 1'b0;
      rst_n = 1'b1;
      sb_q.push_back(mk(0, 0, 0));
      for (int g = 1; g <= 16; g++) sb_q.push_back(mk(g, 0, 4 * g));
      repeat (17) wait_tick(n);

      // One-clock enable=0 in RUN
      repeat (50) @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      check("clr_muted", int'(muted), 1);
      check("clr_gain", int'(dut.gain_q), 0);
      check("clr_div_cnt", int'(dut.div_cnt_q), 0);
      check("clr_dsm_out", int'(dsm_out), 0);
      check("clr_x", int'(dut.x_q), 0);
      enable = 1'b1;
      sb_q.push_back(mk(0, 0, 0));
      wait_tick(n);
      check("reenable_tick_latency", n, 255);
      sb_q.push_back(mk(1, 0, 4));
      wait_tick(n);

      repeat (3) @(negedge clk);
      check("scoreboard_drained", sb_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
